// File: rtl/sdram_sched_pkg.sv
// Shared types and constants for the C64 SDRAM request scheduler.
package sdram_sched_pkg;

  localparam int unsigned ADDR_W         = 25;
  localparam int unsigned SLOT_START     = 0;
  localparam int unsigned DEF_SLOT_LEN   = 8;
  localparam int unsigned DEF_STROBE_LEN = 4;
  localparam int unsigned DEF_ACK_SLOT   = 6;

  typedef enum logic [2:0] {
    GNT_NONE = 3'd0,
    GNT_REF  = 3'd1,
    GNT_VID  = 3'd2,
    GNT_CPU  = 3'd3,
    GNT_DL   = 3'd4
  } gnt_t;

  function automatic logic is_client(input gnt_t g);
    return (g == GNT_VID) || (g == GNT_CPU) || (g == GNT_DL);
  endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Refresh interval counter with a saturating 2-bit count of owed refreshes.
module sdram_refresh_timer #(
  parameter int unsigned REFRESH_INTERVAL = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       consume,
  output logic [1:0] pending
);

  localparam int unsigned TW = $clog2(REFRESH_INTERVAL);
  localparam logic [TW-1:0] TIMER_LAST = TW'(REFRESH_INTERVAL - 1);

  logic [TW-1:0] r_timer;
  logic [1:0]    r_pending;
  logic          w_tick;

  assign w_tick = enable && (r_timer == TIMER_LAST);

  // A tick and a consume in the same clock cancel out.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_timer   <= '0;
      r_pending <= '0;
    end else begin
      if (enable) r_timer <= w_tick ? '0 : r_timer + 1'b1;
      unique case ({w_tick, consume})
        2'b10:   if (r_pending != 2'd3) r_pending <= r_pending + 1'b1;
        2'b01:   if (r_pending != 2'd0) r_pending <= r_pending - 1'b1;
        default: ;
      endcase
    end
  end

  assign pending = r_pending;

endmodule

// File: rtl/sdram_req_sched.sv
// Slot-based VIC/CPU/download scheduler driving the SDRAM controller strobes.
// Define SDRAM_SCHED_RR_EN for round-robin between CPU and download.
module sdram_req_sched
  import sdram_sched_pkg::*;
#(
  parameter int unsigned SLOT_LEN         = DEF_SLOT_LEN,
  parameter int unsigned STROBE_LEN       = DEF_STROBE_LEN,
  parameter int unsigned ACK_SLOT         = DEF_ACK_SLOT,
  parameter int unsigned REFRESH_INTERVAL = 500,
  parameter int unsigned INIT_SLOTS       = 40
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              vid_req,
  input  logic [ADDR_W-1:0] vid_addr,
  output logic              vid_ack,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  output logic              cpu_ack,
  input  logic              dl_req,
  input  logic [ADDR_W-1:0] dl_addr,
  output logic              dl_ack,
  output logic              mem_ce,
  output logic              mem_we,
  output logic              mem_refresh,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              init_done
);

  localparam int unsigned SW = $clog2(SLOT_LEN);
  localparam int unsigned IW = $clog2(INIT_SLOTS);
  localparam logic [SW-1:0] SLOT_FIRST = SW'(SLOT_START);
  localparam logic [SW-1:0] SLOT_LAST  = SW'(SLOT_LEN - 1);
  localparam logic [SW-1:0] STROBE_END = SW'(STROBE_LEN);
  localparam logic [SW-1:0] ACK_IDX    = SW'(ACK_SLOT);
  localparam logic [IW-1:0] INIT_LAST  = IW'(INIT_SLOTS - 1);

  logic [SW-1:0]     r_slot;
  gnt_t              r_gnt;
  logic [IW-1:0]     r_init_cnt;
  logic              r_init_done;
  logic              r_mem_ce, r_mem_we, r_mem_refresh;
  logic [ADDR_W-1:0] r_mem_addr;
  logic              r_vid_ack, r_cpu_ack, r_dl_ack;

  logic [1:0]        w_pending;
  logic              w_slot_start, w_consume, w_cpu_wins, w_we_sel;
  gnt_t              w_choice;
  logic [ADDR_W-1:0] w_addr_sel;

  assign w_slot_start = (r_slot == SLOT_FIRST);
  assign w_consume    = w_slot_start && r_init_done && (w_choice == GNT_REF);

  sdram_refresh_timer #(
    .REFRESH_INTERVAL(REFRESH_INTERVAL)
  ) u_refresh_timer (
    .clk    (clk),
    .reset  (reset),
    .enable (r_init_done),
    .consume(w_consume),
    .pending(w_pending)
  );

`ifdef SDRAM_SCHED_RR_EN
  // r_last_dl = 1 means download was the last of the two served.
  logic r_last_dl;

  assign w_cpu_wins = cpu_req && (!dl_req || r_last_dl);

  always_ff @(posedge clk) begin
    if (reset) r_last_dl <= 1'b1;
    else if (w_slot_start && (w_choice == GNT_CPU)) r_last_dl <= 1'b0;
    else if (w_slot_start && (w_choice == GNT_DL)) r_last_dl <= 1'b1;
  end
`else
  assign w_cpu_wins = cpu_req;
`endif

  always_comb begin
    w_choice = GNT_NONE;
    if (!r_init_done)            w_choice = GNT_REF;
    else if (w_pending >= 2'd2)  w_choice = GNT_REF;
    else if (vid_req)            w_choice = GNT_VID;
    else if (w_cpu_wins)         w_choice = GNT_CPU;
    else if (dl_req)             w_choice = GNT_DL;
    else if (w_pending != 2'd0)  w_choice = GNT_REF;
  end

  always_comb begin
    w_addr_sel = r_mem_addr;
    w_we_sel   = 1'b0;
    unique case (w_choice)
      GNT_VID: w_addr_sel = vid_addr;
      GNT_CPU: begin
        w_addr_sel = cpu_addr;
        w_we_sel   = cpu_we;
      end
      GNT_DL: begin
        w_addr_sel = dl_addr;
        w_we_sel   = 1'b1;
      end
      default: ;
    endcase
  end

  // Strobes rise one clock after slot start and hold for STROBE_LEN clocks.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_slot        <= '0;
      r_gnt         <= GNT_NONE;
      r_init_cnt    <= '0;
      r_init_done   <= 1'b0;
      r_mem_ce      <= 1'b0;
      r_mem_we      <= 1'b0;
      r_mem_refresh <= 1'b0;
      r_mem_addr    <= '0;
      r_vid_ack     <= 1'b0;
      r_cpu_ack     <= 1'b0;
      r_dl_ack      <= 1'b0;
    end else begin
      r_slot <= (r_slot == SLOT_LAST) ? '0 : r_slot + 1'b1;

      if (w_slot_start) begin
        r_gnt         <= w_choice;
        r_mem_ce      <= is_client(w_choice);
        r_mem_refresh <= (w_choice == GNT_REF);
        r_mem_we      <= w_we_sel;
        if (is_client(w_choice)) r_mem_addr <= w_addr_sel;
      end else if (r_slot == STROBE_END) begin
        r_mem_ce      <= 1'b0;
        r_mem_refresh <= 1'b0;
        r_mem_we      <= 1'b0;
      end

      r_vid_ack <= (r_slot == ACK_IDX) && (r_gnt == GNT_VID);
      r_cpu_ack <= (r_slot == ACK_IDX) && (r_gnt == GNT_CPU);
      r_dl_ack  <= (r_slot == ACK_IDX) && (r_gnt == GNT_DL);

      if (!r_init_done && (r_slot == SLOT_LAST)) begin
        if (r_init_cnt == INIT_LAST) r_init_done <= 1'b1;
        else                         r_init_cnt  <= r_init_cnt + 1'b1;
      end
    end
  end

  assign mem_ce      = r_mem_ce;
  assign mem_we      = r_mem_we;
  assign mem_refresh = r_mem_refresh;
  assign mem_addr    = r_mem_addr;
  assign vid_ack     = r_vid_ack;
  assign cpu_ack     = r_cpu_ack;
  assign dl_ack      = r_dl_ack;
  assign init_done   = r_init_done;

endmodule

// File: tb/tb_sdram_req_sched.sv
// Scoreboard bench for sdram_req_sched: expected accesses queued at drive time, acks captured by a monitor.
module tb_sdram_req_sched;

  localparam int SLOT   = 8;
  localparam int STROBE = 4;
  localparam int ACK    = 6;
  localparam int RI     = 500;
  localparam int INIT   = 40;
  localparam int WHO_VID = 1;
  localparam int WHO_CPU = 2;
  localparam int WHO_DL  = 3;

  typedef struct { int who; logic [24:0] addr; logic we; int ce_len; int dly; } obs_t;
  typedef struct { int who; logic [24:0] addr; logic we; } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        vid_req = 1'b0, cpu_req = 1'b0, cpu_we = 1'b0, dl_req = 1'b0;
  logic [24:0] vid_addr = '0, cpu_addr = '0, dl_addr = '0;
  logic        vid_ack, cpu_ack, dl_ack, mem_ce, mem_we, mem_refresh, init_done;
  logic [24:0] mem_addr;

  int checks = 0;
  int errors = 0;

  obs_t obs_q[$];
  exp_t sb_q[$];
  int   ref_cyc_q[$];
  int   cyc = 0, ref_edges = 0, ce_edges = 0, ack_cnt = 0, overlap_cnt = 0;

  sdram_req_sched #(
    .SLOT_LEN(SLOT), .STROBE_LEN(STROBE), .ACK_SLOT(ACK),
    .REFRESH_INTERVAL(RI), .INIT_SLOTS(INIT)
  ) dut (
    .clk(clk), .reset(reset),
    .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_ack(cpu_ack),
    .dl_req(dl_req), .dl_addr(dl_addr), .dl_ack(dl_ack),
    .mem_ce(mem_ce), .mem_we(mem_we), .mem_refresh(mem_refresh),
    .mem_addr(mem_addr), .init_done(init_done)
  );

  initial forever #5 clk = ~clk;

  // Monitor: samples on the falling edge, records strobe edges and completed accesses.
  initial begin
    logic        prev_ce, prev_ref, cur_we;
    logic [24:0] cur_addr;
    int          ce_len, rise_cyc;
    obs_t        o;
    prev_ce = 1'b0; prev_ref = 1'b0; cur_we = 1'b0; cur_addr = '0;
    ce_len = 0; rise_cyc = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (mem_ce && mem_refresh) overlap_cnt++;
      if (mem_refresh && !prev_ref) begin
        ref_edges++;
        ref_cyc_q.push_back(cyc);
      end
      if (mem_ce && !prev_ce) begin
        ce_edges++;
        cur_addr = mem_addr;
        cur_we   = mem_we;
        ce_len   = 0;
        rise_cyc = cyc;
      end
      if (mem_ce) ce_len++;
      if (vid_ack || cpu_ack || dl_ack) begin
        ack_cnt++;
        o.who    = ({vid_ack, cpu_ack, dl_ack} == 3'b100) ? WHO_VID :
                   ({vid_ack, cpu_ack, dl_ack} == 3'b010) ? WHO_CPU :
                   ({vid_ack, cpu_ack, dl_ack} == 3'b001) ? WHO_DL : 7;
        o.addr   = cur_addr;
        o.we     = cur_we;
        o.ce_len = ce_len;
        o.dly    = cyc - rise_cyc;
        obs_q.push_back(o);
      end
      prev_ce  = mem_ce;
      prev_ref = mem_refresh;
    end
  end

  task automatic test_reset();
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({mem_ce, mem_we, mem_refresh} !== 3'b000 || mem_addr !== 25'h0) begin
      errors++;
      $display("FAIL reset_mem got ce=%b we=%b ref=%b addr=%h required 0", mem_ce, mem_we, mem_refresh, mem_addr);
    end
    checks++;
    if ({vid_ack, cpu_ack, dl_ack} !== 3'b000) begin
      errors++;
      $display("FAIL reset_acks got %b required 000", {vid_ack, cpu_ack, dl_ack});
    end
    checks++;
    if (init_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_init_done got %b required 0", init_done);
    end
    reset = 1'b0;
  endtask

  // Call right after reset has been released (1 time unit after an edge).
  task automatic test_init(input string tag);
    int n, b_ref, b_ce, b_idx, bad;
    b_ref = ref_edges; b_ce = ce_edges; b_idx = ref_cyc_q.size();
    n = 0;
    while (init_done !== 1'b1 && n < 400) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (n != SLOT * INIT) begin
      errors++;
      $display("FAIL %s_done_clock got %0d required %0d", tag, n, SLOT * INIT);
    end
    checks++;
    if (ref_edges - b_ref != INIT) begin
      errors++;
      $display("FAIL %s_refresh_edges got %0d required %0d", tag, ref_edges - b_ref, INIT);
    end
    checks++;
    if (ce_edges != b_ce) begin
      errors++;
      $display("FAIL %s_ce_edges got %0d required 0", tag, ce_edges - b_ce);
    end
    bad = 0;
    for (int i = b_idx + 1; i < ref_cyc_q.size(); i++)
      if (ref_cyc_q[i] - ref_cyc_q[i-1] != SLOT) bad++;
    checks++;
    if (bad != 0) begin
      errors++;
      $display("FAIL %s_refresh_spacing got %0d bad gaps required 0", tag, bad);
    end
  endtask

  task automatic test_vid();
    exp_t e; obs_t o; int n;
    e.who = WHO_VID; e.addr = 25'h0012345; e.we = 1'b0;
    sb_q.push_back(e);
    vid_addr = 25'h0012345; vid_req = 1'b1;
    n = 0;
    while (vid_ack !== 1'b1 && n < 64) begin
      @(posedge clk); #1; n++;
    end
    vid_req = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (obs_q.size() == 0) begin
      errors++;
      $display("FAIL vid_ack got none required 1");
    end else begin
      o = obs_q.pop_front(); e = sb_q.pop_front();
      if (o.who !== e.who || o.addr !== e.addr || o.we !== e.we) begin
        errors++;
        $display("FAIL vid_access got who=%0d addr=%h we=%b required who=%0d addr=%h we=%b",
                 o.who, o.addr, o.we, e.who, e.addr, e.we);
      end
      checks++;
      if (o.ce_len != STROBE) begin
        errors++;
        $display("FAIL vid_ce_len got %0d required %0d", o.ce_len, STROBE);
      end
      checks++;
      if (o.dly != ACK) begin
        errors++;
        $display("FAIL vid_ack_slot got %0d required %0d", o.dly, ACK);
      end
    end
  endtask

  task automatic run_and_compare(input string tag, input int nacc);
    obs_t o; exp_t e;
    for (int i = 0; i < nacc; i++) begin
      checks++;
      if (obs_q.size() == 0 || sb_q.size() == 0) begin
        errors++;
        $display("FAIL %s_missing got %0d acks required %0d", tag, i, nacc);
        break;
      end
      o = obs_q.pop_front(); e = sb_q.pop_front();
      if (o.who !== e.who || o.addr !== e.addr || o.we !== e.we) begin
        errors++;
        $display("FAIL %s_%0d got who=%0d addr=%h we=%b required who=%0d addr=%h we=%b",
                 tag, i, o.who, o.addr, o.we, e.who, e.addr, e.we);
      end
    end
  endtask

  task automatic test_vid_cpu();
    exp_t e; int n, b_ack;
    e.who = WHO_VID; e.addr = 25'h00ABCDE; e.we = 1'b0; sb_q.push_back(e);
    e.who = WHO_CPU; e.addr = 25'h1FFFFFF; e.we = 1'b1; sb_q.push_back(e);
    b_ack = ack_cnt;
    vid_addr = 25'h00ABCDE; cpu_addr = 25'h1FFFFFF; cpu_we = 1'b1;
    vid_req = 1'b1; cpu_req = 1'b1;
    n = 0;
    while ((vid_req || cpu_req) && n < 200) begin
      @(posedge clk); #1; n++;
      if (vid_ack) vid_req = 1'b0;
      if (cpu_ack) cpu_req = 1'b0;
    end
    checks++;
    if (vid_req || cpu_req) begin
      errors++;
      $display("FAIL vid_cpu_timeout got pending vid=%b cpu=%b required none", vid_req, cpu_req);
      vid_req = 1'b0; cpu_req = 1'b0;
    end
    repeat (2 * SLOT) @(posedge clk);
    #1;
    run_and_compare("vid_cpu", 2);
    checks++;
    if (ack_cnt - b_ack != 2) begin
      errors++;
      $display("FAIL vid_cpu_ack_count got %0d required 2", ack_cnt - b_ack);
    end
    cpu_we = 1'b0;
  endtask

  task automatic test_dl();
    exp_t e; int n;
    e.who = WHO_DL; e.addr = 25'h0F00F00; e.we = 1'b1; sb_q.push_back(e);
    dl_addr = 25'h0F00F00; dl_req = 1'b1;
    n = 0;
    while (dl_ack !== 1'b1 && n < 64) begin
      @(posedge clk); #1; n++;
    end
    dl_req = 1'b0;
    @(negedge clk); #1;
    run_and_compare("dl", 1);
  endtask

  task automatic test_cpu_dl();
    exp_t e; int n, acks;
    for (int i = 0; i < 4; i++) begin
`ifdef SDRAM_SCHED_RR_EN
      e.who = (i % 2 == 0) ? WHO_CPU : WHO_DL;
`else
      e.who = WHO_CPU;
`endif
      e.addr = (e.who == WHO_CPU) ? 25'h0000100 : 25'h1000200;
      e.we   = (e.who == WHO_DL);
      sb_q.push_back(e);
    end
    cpu_we = 1'b0; cpu_addr = 25'h0000100; dl_addr = 25'h1000200;
    cpu_req = 1'b1; dl_req = 1'b1;
    n = 0; acks = 0;
    while (acks < 4 && n < 600) begin
      @(posedge clk); #1; n++;
      if (cpu_ack || dl_ack) acks++;
    end
    cpu_req = 1'b0; dl_req = 1'b0;
    checks++;
    if (acks != 4) begin
      errors++;
      $display("FAIL cpu_dl_acks got %0d required 4", acks);
    end
    @(negedge clk); #1;
    run_and_compare("cpu_dl", acks);
  endtask

  task automatic test_starve();
    obs_t o; int n, b_ref, b_idx, max_gap, vids;
    b_ref = ref_edges; b_idx = ref_cyc_q.size();
    vid_addr = 25'h0155AA0; vid_req = 1'b1;
    for (n = 0; n < 1200; n++) begin
      @(posedge clk); #1;
    end
    n = 0;
    while (vid_ack !== 1'b1 && n < 64) begin
      @(posedge clk); #1; n++;
    end
    vid_req = 1'b0;
    repeat (2 * SLOT) @(posedge clk);
    #1;
    checks++;
    if (ref_edges - b_ref < 1) begin
      errors++;
      $display("FAIL starve_refresh got %0d refreshes required >= 1", ref_edges - b_ref);
    end
    max_gap = 0;
    for (int i = (b_idx > 0 ? b_idx : 1); i < ref_cyc_q.size(); i++)
      if (ref_cyc_q[i] - ref_cyc_q[i-1] > max_gap) max_gap = ref_cyc_q[i] - ref_cyc_q[i-1];
    checks++;
    if (max_gap > 2 * RI + 2 * SLOT) begin
      errors++;
      $display("FAIL starve_refresh_gap got %0d required <= %0d", max_gap, 2 * RI + 2 * SLOT);
    end
    vids = 0;
    while (obs_q.size() > 0) begin
      o = obs_q.pop_front();
      vids++;
      checks++;
      if (o.who !== WHO_VID || o.addr !== 25'h0155AA0 || o.we !== 1'b0) begin
        errors++;
        $display("FAIL starve_access got who=%0d addr=%h we=%b required who=1 addr=0155aa0 we=0",
                 o.who, o.addr, o.we);
      end
    end
    checks++;
    if (vids < 140) begin
      errors++;
      $display("FAIL starve_vid_count got %0d required >= 140", vids);
    end
  endtask

  task automatic test_reset_mid();
    int n, b_ack;
    b_ack = ack_cnt;
    cpu_we = 1'b1; cpu_addr = 25'h0000ABC; cpu_req = 1'b1;
    n = 0;
    while (mem_ce !== 1'b1 && n < 64) begin
      @(posedge clk); #1; n++;
    end
    checks++;
    if (mem_ce !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ce got %b required 1", mem_ce);
    end
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1; cpu_req = 1'b0; cpu_we = 1'b0;
    @(posedge clk); #1;
    checks++;
    if ({mem_ce, mem_we, mem_refresh, init_done, vid_ack, cpu_ack, dl_ack} !== 7'b0 || mem_addr !== 25'h0) begin
      errors++;
      $display("FAIL reset_mid_outputs got ce=%b we=%b ref=%b done=%b addr=%h required all 0",
               mem_ce, mem_we, mem_refresh, init_done, mem_addr);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    test_init("reinit");
    checks++;
    if (ack_cnt != b_ack) begin
      errors++;
      $display("FAIL reset_mid_ack got %0d acks required 0", ack_cnt - b_ack);
    end
  endtask

  task automatic test_exclusive();
    checks++;
    if (overlap_cnt != 0) begin
      errors++;
      $display("FAIL strobe_exclusive got %0d overlapping clocks required 0", overlap_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_init("init");
    test_vid();
    test_vid_cpu();
    test_dl();
    test_cpu_dl();
    test_starve();
    test_reset_mid();
    test_exclusive();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
